// File: rtl/suma_productos_filtrada.sv
// suma_productos_filtrada: pipelined sum-of-products over an input bus with
// run-time loadable AND masks and a persistence filter on the result.
module suma_productos_filtrada #(
    parameter int ANCHO    = 4,
    parameter int TERMINOS = 2,
    parameter int FILTRO   = 3,
    localparam int IW = (TERMINOS > 1) ? $clog2(TERMINOS) : 1,
    localparam int CW = (FILTRO > 1) ? $clog2(FILTRO) : 1
) (
    input  logic                Reloj,
    input  logic                Reset,
    input  logic [ANCHO-1:0]    Entrada,
    input  logic                EntradaValida,
    input  logic                CargaValida,
    input  logic [IW-1:0]       CargaIndice,
    input  logic [ANCHO-1:0]    CargaMascara,
    output logic [TERMINOS-1:0] Terminos,
    output logic                SumaValida,
    output logic                SumaProductos,
    output logic                Cambio
);

    function automatic logic [ANCHO-1:0] mascara_inicial(input int k);
        logic [ANCHO-1:0] m;
        m = '0;
        for (int b = 0; b < ANCHO; b++)
            m[b] = (b == 2 * k) || (b == 2 * k + 1);
        return m;
    endfunction

    logic [ANCHO-1:0]    mascara [TERMINOS];
    logic [ANCHO-1:0]    muestra;
    logic                v1;
    logic                v2;
    logic                cruda;
    logic [TERMINOS-1:0] aciertos;
    logic [CW-1:0]       cuenta;

    // Indices at or beyond TERMINOS match no k, so they are dropped here.
    always_ff @(posedge Reloj) begin
        if (Reset) begin
            for (int k = 0; k < TERMINOS; k++)
                mascara[k] <= mascara_inicial(k);
        end else if (CargaValida) begin
            for (int k = 0; k < TERMINOS; k++)
                if (CargaIndice == IW'(k))
                    mascara[k] <= CargaMascara;
        end
    end

    always_comb begin
        aciertos = '0;
        for (int k = 0; k < TERMINOS; k++)
            aciertos[k] = (|mascara[k]) &&
                          ((muestra & mascara[k]) == mascara[k]);
    end

    always_ff @(posedge Reloj) begin
        if (Reset) begin
            muestra <= '0;
            v1      <= 1'b0;
        end else begin
            v1 <= EntradaValida;
            if (EntradaValida)
                muestra <= Entrada;
        end
    end

    always_ff @(posedge Reloj) begin
        if (Reset) begin
            Terminos <= '0;
            cruda    <= 1'b0;
            v2       <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                Terminos <= aciertos;
                cruda    <= |aciertos;
            end
        end
    end

    // Gaps (v2=0) leave cuenta untouched so the run survives them.
    always_ff @(posedge Reloj) begin
        if (Reset) begin
            cuenta        <= '0;
            SumaValida    <= 1'b0;
            SumaProductos <= 1'b0;
            Cambio        <= 1'b0;
        end else begin
            SumaValida <= v2;
            Cambio     <= 1'b0;
            if (v2) begin
                if (cruda == SumaProductos) begin
                    cuenta <= '0;
                end else if (cuenta == CW'(FILTRO - 1)) begin
                    SumaProductos <= cruda;
                    cuenta        <= '0;
                    Cambio        <= 1'b1;
                end else begin
                    cuenta <= cuenta + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_suma_productos_filtrada.sv
// Bench for suma_productos_filtrada: default instance (4,2,3) and a swept
// instance (7,5,1), checked against a transaction model plus literals.
module tb_suma_productos_filtrada;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] ent_a, msk_a;
    logic       ev_a, cv_a;
    logic [0:0] ci_a;
    logic [1:0] ter_a;
    logic       sv_a, sp_a, ch_a;

    logic [6:0] ent_b, msk_b;
    logic       ev_b, cv_b;
    logic [2:0] ci_b;
    logic [4:0] ter_b;
    logic       sv_b, sp_b, ch_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 8;
    bit armed = 1'b0;

    suma_productos_filtrada #(.ANCHO(4), .TERMINOS(2), .FILTRO(3)) dut_a (
        .Reloj(clk), .Reset(rst), .Entrada(ent_a), .EntradaValida(ev_a),
        .CargaValida(cv_a), .CargaIndice(ci_a), .CargaMascara(msk_a),
        .Terminos(ter_a), .SumaValida(sv_a), .SumaProductos(sp_a),
        .Cambio(ch_a)
    );

    suma_productos_filtrada #(.ANCHO(7), .TERMINOS(5), .FILTRO(1)) dut_b (
        .Reloj(clk), .Reset(rst), .Entrada(ent_b), .EntradaValida(ev_b),
        .CargaValida(cv_b), .CargaIndice(ci_b), .CargaMascara(msk_b),
        .Terminos(ter_b), .SumaValida(sv_b), .SumaProductos(sp_b),
        .Cambio(ch_b)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction model ----------------
    int nw [2] = '{4, 7};
    int nt [2] = '{2, 5};
    int nf [2] = '{3, 1};

    logic [6:0] mm    [2][5];
    logic       sl_v  [2][8];
    logic [4:0] sl_t  [2][8];
    logic       sl_s  [2][8];
    logic       sl_c  [2][8];
    logic [4:0] e_ter [2];
    logic       e_out [2];
    logic       e_sp  [2];
    int         run   [2];

    function automatic logic [6:0] dflt(input int n, input int k);
        int v;
        v = (3 << (2 * k)) & ((1 << n) - 1);
        return 7'(v);
    endfunction

    task automatic model_reset(input int d);
        for (int k = 0; k < 5; k++)
            mm[d][k] = (k < nt[d]) ? dflt(nw[d], k) : 7'd0;
        for (int s = 0; s < 8; s++)
            sl_v[d][s] = 1'b0;
        e_ter[d] = '0;
        e_out[d] = 1'b0;
        e_sp[d]  = 1'b0;
        run[d]   = 0;
    endtask

    always @(posedge clk) begin
        logic [6:0] x, lm;
        logic [4:0] at, act_t;
        logic       ev, lv, cr, chg, exv, exc, asv, asp, ach;
        int         li, s1, s2, s3;
        #1;
        cyc++;
        s1 = (cyc - 1) % 8;
        s2 = (cyc - 2) % 8;
        s3 = (cyc - 3) % 8;
        if (rst) armed = 1'b1;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                x = {3'b0, ent_a}; ev = ev_a; lv = cv_a;
                li = int'(ci_a); lm = {3'b0, msk_a};
                act_t = {3'b0, ter_a}; asv = sv_a; asp = sp_a; ach = ch_a;
            end else begin
                x = ent_b; ev = ev_b; lv = cv_b;
                li = int'(ci_b); lm = msk_b;
                act_t = ter_b; asv = sv_b; asp = sp_b; ach = ch_b;
            end
            if (rst) begin
                model_reset(d);
            end else begin
                if (lv && li < nt[d]) mm[d][li] = lm;
                at  = '0;
                chg = 1'b0;
                if (ev) begin
                    for (int k = 0; k < nt[d]; k++)
                        at[k] = (mm[d][k] != 0) &&
                                ((x & mm[d][k]) == mm[d][k]);
                    cr = |at;
                    run[d] = (cr != e_out[d]) ? run[d] + 1 : 0;
                    if (run[d] == nf[d]) begin
                        e_out[d] = cr;
                        run[d]   = 0;
                        chg      = 1'b1;
                    end
                end
                sl_v[d][s1] = ev;
                sl_t[d][s1] = at;
                sl_s[d][s1] = e_out[d];
                sl_c[d][s1] = chg;
            end
            if (sl_v[d][s2]) e_ter[d] = sl_t[d][s2];
            exv = sl_v[d][s3];
            exc = exv && sl_c[d][s3];
            if (exv) e_sp[d] = sl_s[d][s3];
            if (armed) begin
                chk($sformatf("m%0d.terminos", d), act_t, e_ter[d]);
                chk($sformatf("m%0d.suma_valida", d), asv, exv);
                chk($sformatf("m%0d.suma", d), asp, e_sp[d]);
                chk($sformatf("m%0d.cambio", d), ach, exc);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic sa(input logic [3:0] v);
        ent_a = v; ev_a = 1'b1;
        tick();
        ev_a = 1'b0;
    endtask

    task automatic la(input logic [0:0] i, input logic [3:0] m);
        ci_a = i; msk_a = m; cv_a = 1'b1;
        tick();
        cv_a = 1'b0;
    endtask

    task automatic sb(input logic [6:0] v);
        ent_b = v; ev_b = 1'b1;
        tick();
        ev_b = 1'b0;
    endtask

    task automatic lb(input logic [2:0] i, input logic [6:0] m);
        ci_b = i; msk_b = m; cv_b = 1'b1;
        tick();
        cv_b = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ent_a = '0; msk_a = '0; ev_a = 1'b0; cv_a = 1'b0; ci_a = '0;
        ent_b = '0; msk_b = '0; ev_b = 1'b0; cv_b = 1'b0; ci_b = '0;
        tick(); tick();
        chk("reset.terminos", ter_a, 2'b00);
        chk("reset.suma", sp_a, 1'b0);
        rst = 1'b0;

        // rising edge of the filtered output
        sa(4'b0011); sa(4'b0011);
        chk("rise.terminos", ter_a, 2'b01);
        sa(4'b0011);
        tick();
        chk("rise.early", sp_a, 1'b0);
        tick();
        chk("rise.suma", sp_a, 1'b1);
        chk("rise.cambio", ch_a, 1'b1);

        // falling edge
        sa(4'b0101); sa(4'b0101); sa(4'b0101);
        tick();
        chk("fall.early", sp_a, 1'b1);
        tick();
        chk("fall.suma", sp_a, 1'b0);
        chk("fall.cambio", ch_a, 1'b1);

        // rejection, then gaps that must not clear the run
        sa(4'b1100); sa(4'b1100); sa(4'b0000); sa(4'b1100); sa(4'b1100);
        tick(); tick(); tick();
        chk("reject.suma", sp_a, 1'b0);
        tick(); tick(); tick(); tick();
        sa(4'b1100);
        tick(); tick();
        chk("gap.suma", sp_a, 1'b1);
        chk("gap.cambio", ch_a, 1'b1);

        // reprogramming
        la(1'b0, 4'b1001);
        sa(4'b1001);
        tick();
        chk("load0.terminos", ter_a, 2'b01);
        la(1'b1, 4'b0000);
        sa(4'b1100);
        tick();
        chk("disabled.terminos", ter_a, 2'b00);

        // load in the same cycle as the sample takes effect
        ci_a = 1'b0; msk_a = 4'b0100; cv_a = 1'b1;
        sa(4'b0011);
        cv_a = 1'b0;
        tick();
        chk("same_cycle.terminos", ter_a, 2'b00);
        la(1'b0, 4'b0011);
        sa(4'b0011);
        la(1'b0, 4'b0100);
        chk("next_cycle.terminos", ter_a, 2'b01);

        // reset with samples in flight; load during reset is ignored
        sa(4'b0100); sa(4'b0100);
        ent_a = 4'b0100; ev_a = 1'b1; rst = 1'b1;
        ci_a = 1'b1; msk_a = 4'b0001; cv_a = 1'b1;
        tick();
        rst = 1'b0; ev_a = 1'b0; cv_a = 1'b0;
        chk("midrst.terminos", ter_a, 2'b00);
        chk("midrst.valida", sv_a, 1'b0);
        chk("midrst.suma", sp_a, 1'b0);
        chk("midrst.cambio", ch_a, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst.no_valida", sv_a, 1'b0);
        end
        sa(4'b0011); sa(4'b1100);
        chk("restored.term0", ter_a, 2'b01);
        tick();
        chk("restored.term1", ter_a, 2'b10);
        tick(); tick(); tick();

        // swept instance: defaults, FILTRO=1 following every sample
        sb(7'b1000000); sb(7'b1111111);
        chk("b.term3", ter_b, 5'b01000);
        sb(7'b0000000);
        chk("b.all_ones", ter_b, 5'b01111);
        chk("b.suma1", sp_b, 1'b1);
        chk("b.cambio1", ch_b, 1'b1);
        sb(7'b0000011);
        chk("b.zero", ter_b, 5'b00000);
        chk("b.cambio_hold", ch_b, 1'b0);
        tick();
        chk("b.term0", ter_b, 5'b00001);
        chk("b.suma0", sp_b, 1'b0);
        tick();
        chk("b.suma_back", sp_b, 1'b1);

        // out-of-range loads ignored; back-to-back loads, last wins
        lb(3'd5, 7'b0000001);
        lb(3'd7, 7'b0000001);
        lb(3'd4, 7'b0000001);
        lb(3'd4, 7'b0100000);
        sb(7'b0000001); sb(7'b0100000);
        chk("b.oob", ter_b, 5'b00000);
        tick();
        chk("b.last_wins", ter_b, 5'b10000);
        tick(); tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/suma_productos_filtrada.md
# suma_productos_filtrada

Parametrised, pipelined sum-of-products evaluator. It generalises the fixed 4-input `(E1·E0) + (E3·E2)` decoder to ANCHO inputs and TERMINOS product terms. Each term's AND mask is run-time loadable. The result passes through a persistence filter that only changes the output after FILTRO consecutive disagreeing samples. It sits between the input capture logic and the control decoders, wherever a debounced, reprogrammable logic function of an input bus is needed.

## Interface
Parameters:
- ANCHO, 4: input bus width (≥2).
- TERMINOS, 2: number of product terms (≥1).
- FILTRO, 3: consecutive valid disagreeing samples required to change the output (≥1; 1 = no filtering).

Ports:
- Reloj  input  1  single clock, all state on rising edge.
- Reset  input  1  synchronous, active-high.
- Entrada  input  ANCHO  sample bus.
- EntradaValida  input  1  Entrada is sampled this cycle.
- CargaValida  input  1  write CargaMascara into term CargaIndice this cycle.
- CargaIndice  input  max(1,$clog2(TERMINOS))  term index.
- CargaMascara  input  ANCHO  AND mask: bit set = input bit participates.
- Terminos  output  TERMINOS  registered per-term hit vector.
- SumaValida  output  1  one-cycle pulse, filtered result updated.
- SumaProductos  output  1  filtered sum-of-products.
- Cambio  output  1  one-cycle pulse when SumaProductos toggles.

## Operation
- Mask memory: TERMINOS × ANCHO register.
  - On Reset, term k gets mask with bits 2k and 2k+1 set; bits ≥ ANCHO are dropped.
  - With defaults this gives term0 = E1·E0 and term1 = E3·E2.
- Term k hits when mask k is non-zero and every masked input bit is 1. An all-zero mask is disabled and never hits; it is not constant-true.
- Cruda = OR of all term hits.
- Load: when CargaValida=1 and CargaIndice<TERMINOS, the mask is written at that edge. An out-of-range index is ignored, with no other side effect.
- Pipeline:
  - Stage 1: capture Entrada when EntradaValida=1; v1 ← EntradaValida.
  - Stage 2: Terminos ← hits of the stage-1 sample; Cruda registered; v2 ← v1. Terminos holds its value when v1=0.
  - Stage 3: filter update when v2=1; SumaValida ← v2.
- Filter: counter Cuenta holds 0..FILTRO-1 and is only updated when v2=1.
  - If Cruda == SumaProductos: Cuenta ← 0.
  - Else if Cuenta == FILTRO-1: SumaProductos ← Cruda; Cuenta ← 0; Cambio pulses.
  - Else: Cuenta ← Cuenta+1.
- Cycles with v2=0 hold Cuenta, so non-valid gaps neither reset nor advance the filter.

## Timing
- Reset values:
  - Terminos=0, SumaValida=0, SumaProductos=0, Cambio=0.
  - Cuenta=0, v1=v2=0, stage-1 sample register=0, masks = defaults above.
- Reset overrides CargaValida and EntradaValida in the same cycle. Reset mid-pipeline discards all in-flight samples; no SumaValida follows.
- Latency:
  - Sample presented in cycle n → Terminos reflects it in cycle n+2.
  - SumaValida=1 and the filtered SumaProductos are visible in cycle n+3. Cambio is coincident with that SumaValida.
- Throughput: one sample per cycle. There is no back-pressure and no ready signal.
- Load/evaluate ordering: a mask written at the edge ending cycle m is used by every stage-2 evaluation at edges after m. Consequences:
  - Sample in cycle n, load in cycle n → evaluated with the new mask.
  - Sample in cycle n, load in cycle n+1 → evaluated with the old mask.
- Back-to-back loads to the same index: the last write wins.
- FILTRO=1: every valid disagreeing sample updates the output immediately. Cuenta stays 0.

## Test plan
- Defaults (ANCHO=4, TERMINOS=2, FILTRO=3):
  - Drive Entrada=4'b0011 valid for 3 cycles → Terminos=2'b01 from cycle 2; SumaProductos rises in cycle 5 with Cambio=1.
  - Then drive 4'b0101 valid ×3 → SumaProductos falls 3 samples later.
- Filter rejection:
  - From output 0, drive 4'b1100, 4'b1100, 4'b0000, 4'b1100, 4'b1100, all valid → SumaProductos stays 0 and Cambio never pulses.
  - Gaps with EntradaValida=0 inserted between two agreeing samples do not reset Cuenta.
- Reprogramming:
  - Load term0 mask=4'b1001, then drive 4'b1001 → term0 hits.
  - Load term1 mask=0 → 4'b1100 yields Terminos=2'b00.
  - Load with CargaIndice=2 (TERMINOS=2... use TERMINOS=3, index 3) → ignored.
- Load/sample collision:
  - Sample 4'b0011 in cycle n with a load of term0=4'b0100 in the same cycle → Terminos[0]=0.
  - Same sample with the load in cycle n+1 → Terminos[0]=1.
- Reset mid-stream:
  - Assert Reset while three valid samples are in flight → all outputs 0 next cycle, no SumaValida afterward, masks restored to defaults.
- Parameter sweep: ANCHO=7, TERMINOS=5, FILTRO=1:
  - Default term3 mask = 7'b1000000 (bit 7 dropped); term4 mask = 0.
  - Output follows every valid sample at latency 3.
